// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory access sequencer: width defaults, FSM encodings
// and the wait-counter sizing helper.
package mem_access_ctrl_pkg;

  localparam int unsigned DATA_WIDTH_DEF  = 32;
  localparam int unsigned ADDR_WIDTH_DEF  = 26;
  localparam logic [ADDR_WIDTH_DEF-1:0] MEM_LIMIT_DEF = 26'h3FFFFFF;
  localparam int unsigned WAIT_CYCLES_DEF = 1;
  localparam int unsigned WAIT_CNT_WIDTH  = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  // Which kind of completion (if any) is being acknowledged at the current edge.
  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2,
    OP_ERR   = 2'd3
  } done_kind_t;

  // Clamp the configured latency into what the 4-bit counter can express (1..15).
  function automatic logic [WAIT_CNT_WIDTH-1:0] wait_load_value(input int unsigned cycles);
    if (cycles == 0) return WAIT_CNT_WIDTH'(1);
    if (cycles > (2 ** WAIT_CNT_WIDTH) - 1) return WAIT_CNT_WIDTH'((2 ** WAIT_CNT_WIDTH) - 1);
    return WAIT_CNT_WIDTH'(cycles);
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Down-counter that times the memory read latency between the access edge and data capture.
module mem_wait_counter
  import mem_access_ctrl_pkg::*;
(
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      load,
  input  logic [WAIT_CNT_WIDTH-1:0] load_val,
  input  logic                      dec,
  output logic [WAIT_CNT_WIDTH-1:0] count,
  output logic                      zero
);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && !zero) begin
      count <= count - WAIT_CNT_WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-word request sequencer in front of the word memory wrapper.
// Optional completion counters (RD_CNT/WR_CNT/ERR_CNT): define MEM_ACCESS_CTRL_PERF_CNT_EN.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int unsigned           ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter logic [ADDR_WIDTH-1:0] MEM_LIMIT   = ADDR_WIDTH'(MEM_LIMIT_DEF),
  parameter int unsigned           WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ,
  input  logic                  WE,
  input  logic [ADDR_WIDTH-1:0] ADDR_IN,
  input  logic [DATA_WIDTH-1:0] WDATA,
  output logic                  BUSY,
  output logic                  ACK,
  output logic                  ERR,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic                  MEM_READ,
  output logic                  MEM_WRITE,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  output logic [DATA_WIDTH-1:0] MEM_DATA_IN,
`ifdef MEM_ACCESS_CTRL_PERF_CNT_EN
  output logic [31:0]           RD_CNT,
  output logic [31:0]           WR_CNT,
  output logic [31:0]           ERR_CNT,
`endif
  input  logic [DATA_WIDTH-1:0] MEM_DATA_OUT
);

  localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LOAD = wait_load_value(WAIT_CYCLES);

  logic [1:0]                state;
  logic                      we_q;
  logic [WAIT_CNT_WIDTH-1:0] wait_count;
  logic                      wait_zero;
  logic                      wait_load;
  logic                      wait_dec;
  logic                      wait_done;
  logic                      accepting;
  logic                      addr_bad;
  logic [ADDR_WIDTH:0]       limit_diff;
  done_kind_t                done_kind;

  mem_wait_counter u_wait_counter (
    .CLK      (CLK),
    .RST      (RST),
    .load     (wait_load),
    .load_val (WAIT_LOAD),
    .dec      (wait_dec),
    .count    (wait_count),
    .zero     (wait_zero)
  );

  assign wait_load = (state == ST_ACCESS);
  assign wait_dec  = (state == ST_WAIT);
  assign accepting = REQ && ((state == ST_IDLE) || (state == ST_RESP));

  // Out-of-range is the borrow of MEM_LIMIT - ADDR_IN; this stays a real datapath
  // check even when MEM_LIMIT is the all-ones address.
  assign limit_diff = {1'b0, MEM_LIMIT} - {1'b0, ADDR_IN};
  assign addr_bad   = limit_diff[ADDR_WIDTH];

  // The access edge loads WAIT_CYCLES, so the capture edge is the one where the count is 1.
  // A zero count is only reachable through a corrupted load and simply ends the wait.
  assign wait_done = (state == ST_WAIT) && (wait_zero || (wait_count == WAIT_CNT_WIDTH'(1)));

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    done_kind = OP_NONE;
    if (accepting && addr_bad) begin
      done_kind = OP_ERR;
    end else if (wait_done) begin
      done_kind = we_q ? OP_WRITE : OP_READ;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ST_IDLE;
      we_q        <= 1'b0;
      BUSY        <= 1'b0;
      ACK         <= 1'b0;
      ERR         <= 1'b0;
      RDATA       <= '0;
      MEM_READ    <= 1'b0;
      MEM_WRITE   <= 1'b0;
      MEM_ADDR    <= '0;
      MEM_DATA_IN <= '0;
    end else begin
      ACK       <= 1'b0;
      ERR       <= 1'b0;
      MEM_READ  <= 1'b0;
      MEM_WRITE <= 1'b0;

      case (state)
        ST_IDLE, ST_RESP: begin
          BUSY  <= 1'b0;
          state <= ST_IDLE;
          if (accepting) begin
            if (addr_bad) begin
              state <= ST_RESP;
              ACK   <= 1'b1;
              ERR   <= 1'b1;
              RDATA <= '0;
            end else begin
              state       <= ST_ACCESS;
              BUSY        <= 1'b1;
              we_q        <= WE;
              MEM_ADDR    <= ADDR_IN;
              MEM_DATA_IN <= WDATA;
              MEM_WRITE   <= WE;
              MEM_READ    <= ~WE;
            end
          end
        end

        ST_ACCESS: begin
          state <= ST_WAIT;
        end

        ST_WAIT: begin
          if (wait_done) begin
            state <= ST_RESP;
            BUSY  <= 1'b0;
            ACK   <= 1'b1;
            if (done_kind == OP_READ) begin
              RDATA <= MEM_DATA_OUT;
            end
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef MEM_ACCESS_CTRL_PERF_CNT_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      RD_CNT  <= '0;
      WR_CNT  <= '0;
      ERR_CNT <= '0;
    end else begin
      case (done_kind)
        OP_READ:  RD_CNT  <= RD_CNT + 32'd1;
        OP_WRITE: WR_CNT  <= WR_CNT + 32'd1;
        OP_ERR:   ERR_CNT <= ERR_CNT + 32'd1;
        default:  ;
      endcase
    end
  end
`else
  // Counters absent: done_kind only steers read-data capture.
`endif

  // The memory must never see both strobes, and an acknowledge never overlaps an access.
  assert property (@(posedge CLK) !(MEM_READ && MEM_WRITE));
  assert property (@(posedge CLK) ACK |-> !BUSY);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: two instances (WAIT_CYCLES=1 and 3, MEM_LIMIT=0xFFF) share
// one stimulus stream and one behavioural memory; a transaction-level model predicts outputs.
module tb_mem_access_ctrl;

  localparam logic [25:0] LIMIT = 26'h0000FFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we  = 1'b0;
  logic        sel = 1'b0;
  logic [25:0] addr  = '0;
  logic [31:0] wdata = '0;
  logic [31:0] mem_dout = '0;
  logic        req1, req3;

  always #5 clk = ~clk;

  assign req1 = req & ~sel;
  assign req3 = req & sel;

  logic        busy1, ack1, err1, mrd1, mwr1;
  logic        busy3, ack3, err3, mrd3, mwr3;
  logic [31:0] rdata1, mdin1, rdata3, mdin3;
  logic [25:0] maddr1, maddr3;
`ifdef MEM_ACCESS_CTRL_PERF_CNT_EN
  logic [31:0] rdc1, wrc1, erc1, rdc3, wrc3, erc3;
`endif

  mem_access_ctrl #(.WAIT_CYCLES(1), .MEM_LIMIT(LIMIT)) u_dut_w1 (
    .CLK(clk), .RST(rst), .REQ(req1), .WE(we), .ADDR_IN(addr), .WDATA(wdata),
    .BUSY(busy1), .ACK(ack1), .ERR(err1), .RDATA(rdata1),
    .MEM_READ(mrd1), .MEM_WRITE(mwr1), .MEM_ADDR(maddr1), .MEM_DATA_IN(mdin1),
`ifdef MEM_ACCESS_CTRL_PERF_CNT_EN
    .RD_CNT(rdc1), .WR_CNT(wrc1), .ERR_CNT(erc1),
`endif
    .MEM_DATA_OUT(mem_dout)
  );

  mem_access_ctrl #(.WAIT_CYCLES(3), .MEM_LIMIT(LIMIT)) u_dut_w3 (
    .CLK(clk), .RST(rst), .REQ(req3), .WE(we), .ADDR_IN(addr), .WDATA(wdata),
    .BUSY(busy3), .ACK(ack3), .ERR(err3), .RDATA(rdata3),
    .MEM_READ(mrd3), .MEM_WRITE(mwr3), .MEM_ADDR(maddr3), .MEM_DATA_IN(mdin3),
`ifdef MEM_ACCESS_CTRL_PERF_CNT_EN
    .RD_CNT(rdc3), .WR_CNT(wrc3), .ERR_CNT(erc3),
`endif
    .MEM_DATA_OUT(mem_dout)
  );

  logic        o_busy, o_ack, o_err, o_mrd, o_mwr;
  logic [31:0] o_rdata, o_mdin;
  logic [25:0] o_maddr;
  assign o_busy  = sel ? busy3  : busy1;
  assign o_ack   = sel ? ack3   : ack1;
  assign o_err   = sel ? err3   : err1;
  assign o_mrd   = sel ? mrd3   : mrd1;
  assign o_mwr   = sel ? mwr3   : mwr1;
  assign o_rdata = sel ? rdata3 : rdata1;
  assign o_mdin  = sel ? mdin3  : mdin1;
  assign o_maddr = sel ? maddr3 : maddr1;
`ifdef MEM_ACCESS_CTRL_PERF_CNT_EN
  logic [31:0] o_rdc, o_wrc, o_erc;
  assign o_rdc = sel ? rdc3 : rdc1;
  assign o_wrc = sel ? wrc3 : wrc1;
  assign o_erc = sel ? erc3 : erc1;
`endif

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Power-on memory contents, identical for the memory and the reference.
  function automatic logic [31:0] init_val(input int a);
    if (a == 16) return 32'hDEADBEEF;
    return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  // Behavioural word memory: operates on the strobed edge, read data held until the next read.
  logic [31:0] mem [int];
  int          rd_strobes = 0;
  int          wr_strobes = 0;
  logic [25:0] last_addr  = '0;

  function automatic logic [31:0] mem_rd(input logic [25:0] a);
    return mem.exists(int'(a[11:0])) ? mem[int'(a[11:0])] : init_val(int'(a[11:0]));
  endfunction

  always @(posedge clk) begin
    if (o_mrd) begin
      mem_dout <= mem_rd(o_maddr);
      rd_strobes++;
      last_addr = o_maddr;
    end
    if (o_mwr) begin
      mem[int'(o_maddr[11:0])] = o_mdin;
      wr_strobes++;
      last_addr = o_maddr;
    end
  end

  // Reference model: each transaction is a start edge n; its acknowledge is due at n+1+W.
  logic [31:0] ref_mem [int];
  int          cyc = 0;
  bit          m_inflight = 1'b0;
  int          m_n = 0;
  int          m_w = 1;
  bit          m_we = 1'b0;
  logic [25:0] m_addr = '0;
  bit          e_busy = 1'b0, e_ack = 1'b0, e_err = 1'b0, e_rd = 1'b0, e_wr = 1'b0;
  logic [25:0] e_addr  = '0;
  logic [31:0] e_din   = '0;
  logic [31:0] e_rdata = '0;
`ifdef MEM_ACCESS_CTRL_PERF_CNT_EN
  logic [31:0] e_rdc = '0, e_wrc = '0, e_erc = '0;
`endif

  function automatic logic [31:0] ref_rd(input logic [25:0] a);
    return ref_mem.exists(int'(a[11:0])) ? ref_mem[int'(a[11:0])] : init_val(int'(a[11:0]));
  endfunction

  always @(posedge clk) begin
    cyc++;
    m_w   = sel ? 3 : 1;
    e_ack = 1'b0;
    e_err = 1'b0;
    e_rd  = 1'b0;
    e_wr  = 1'b0;
    if (rst) begin
      m_inflight = 1'b0;
      e_busy  = 1'b0;
      e_addr  = '0;
      e_din   = '0;
      e_rdata = '0;
`ifdef MEM_ACCESS_CTRL_PERF_CNT_EN
      e_rdc = '0; e_wrc = '0; e_erc = '0;
`endif
    end else if (m_inflight) begin
      if (cyc - m_n == 1 + m_w) begin
        m_inflight = 1'b0;
        e_busy = 1'b0;
        e_ack  = 1'b1;
        if (!m_we) e_rdata = ref_rd(m_addr);
`ifdef MEM_ACCESS_CTRL_PERF_CNT_EN
        if (m_we) e_wrc++; else e_rdc++;
`endif
      end
    end else if (req) begin
      if (addr > LIMIT) begin
        e_busy  = 1'b0;
        e_ack   = 1'b1;
        e_err   = 1'b1;
        e_rdata = '0;
`ifdef MEM_ACCESS_CTRL_PERF_CNT_EN
        e_erc++;
`endif
      end else begin
        m_inflight = 1'b1;
        m_n    = cyc;
        m_we   = we;
        m_addr = addr;
        e_busy = 1'b1;
        e_addr = addr;
        e_din  = wdata;
        e_rd   = !we;
        e_wr   = we;
        if (we) ref_mem[int'(addr[11:0])] = wdata;
      end
    end else begin
      e_busy = 1'b0;
    end
  end

  bit cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy",        64'(o_busy),  64'(e_busy));
      check("ack",         64'(o_ack),   64'(e_ack));
      check("err",         64'(o_err),   64'(e_err));
      check("mem_read",    64'(o_mrd),   64'(e_rd));
      check("mem_write",   64'(o_mwr),   64'(e_wr));
      check("mem_addr",    64'(o_maddr), 64'(e_addr));
      check("mem_data_in", 64'(o_mdin),  64'(e_din));
      check("rdata",       64'(o_rdata), 64'(e_rdata));
`ifdef MEM_ACCESS_CTRL_PERF_CNT_EN
      check("rd_cnt",  64'(o_rdc), 64'(e_rdc));
      check("wr_cnt",  64'(o_wrc), 64'(e_wrc));
      check("err_cnt", 64'(o_erc), 64'(e_erc));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issue one request from a negedge and return how many edges until ACK is seen.
  task automatic do_req(input logic w, input logic [25:0] a, input logic [31:0] d, output int lat);
    lat   = 0;
    req   = 1'b1;
    we    = w;
    addr  = a;
    wdata = d;
    for (int i = 1; i <= 32; i++) begin
      tick();
      req = 1'b0;
      if (o_ack) begin
        lat = i;
        break;
      end
    end
    check("ack_within_budget", 64'(lat != 0), 64'(1));
  endtask

  task automatic random_phase(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      rst   = ($urandom_range(0, 127) == 0);
      req   = ($urandom_range(0, 99) < 45);
      we    = 1'($urandom_range(0, 1));
      wdata = $urandom;
      case ($urandom_range(0, 9))
        0:       addr = LIMIT + 26'($urandom_range(1, 4));
        1:       addr = 26'h3FFFFFF;
        2:       addr = LIMIT;
        default: addr = 26'h10 + 26'($urandom_range(0, 7));
      endcase
      tick();
    end
    rst = 1'b0;
    req = 1'b0;
    repeat (8) tick();
  endtask

  initial begin
    int lat;
    int s_rd, s_wr, acks;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    cmp_en = 1'b1;
    check("reset_busy",  64'(o_busy),  64'(0));
    check("reset_ack",   64'(o_ack),   64'(0));
    check("reset_rdata", 64'(o_rdata), 64'(0));
    tick();

    // Read of preloaded word 0x10, WAIT_CYCLES=1.
    s_rd  = rd_strobes;
    req   = 1'b1;
    we    = 1'b0;
    addr  = 26'h10;
    tick();
    req = 1'b0;
    check("rd_strobe_on",  64'(o_mrd),   64'(1));
    check("rd_busy",       64'(o_busy),  64'(1));
    check("rd_mem_addr",   64'(o_maddr), 64'(26'h10));
    tick();
    check("rd_strobe_off", 64'(o_mrd),   64'(0));
    check("rd_no_early",   64'(o_ack),   64'(0));
    tick();
    check("rd_ack",        64'(o_ack),   64'(1));
    check("rd_err",        64'(o_err),   64'(0));
    check("rd_data",       64'(o_rdata), 64'(32'hDEADBEEF));
    tick();
    check("rd_ack_pulse",  64'(o_ack),   64'(0));
    check("rd_data_held",  64'(o_rdata), 64'(32'hDEADBEEF));
    check("rd_one_strobe", 64'(rd_strobes - s_rd), 64'(1));

    // Write 0x20, then read it back issued in the RESP cycle.
    s_wr = wr_strobes;
    do_req(1'b1, 26'h20, 32'h12345678, lat);
    check("wr_latency", 64'(lat), 64'(3));
    do_req(1'b0, 26'h20, 32'h0, lat);
    check("b2b_ack_gap",  64'(lat),     64'(3));
    check("b2b_rdata",    64'(o_rdata), 64'(32'h12345678));
    check("wr_one_pulse", 64'(wr_strobes - s_wr), 64'(1));
    tick();

    // Out of range, then the last legal address.
    s_rd = rd_strobes;
    s_wr = wr_strobes;
    do_req(1'b0, 26'h1000, 32'h0, lat);
    check("oor_latency", 64'(lat),     64'(1));
    check("oor_err",     64'(o_err),   64'(1));
    check("oor_rdata",   64'(o_rdata), 64'(0));
    tick();
    check("oor_ack_pulse", 64'(o_ack), 64'(0));
    check("oor_no_strobe", 64'((rd_strobes - s_rd) + (wr_strobes - s_wr)), 64'(0));
    do_req(1'b0, LIMIT, 32'h0, lat);
    check("limit_latency", 64'(lat),   64'(3));
    check("limit_err",     64'(o_err), 64'(0));
    tick();

    // REQ for 0x30 while a read of 0x10 is in flight is dropped.
    s_rd = rd_strobes;
    acks = 0;
    req  = 1'b1;
    we   = 1'b0;
    addr = 26'h10;
    tick();
    addr = 26'h30;
    tick();
    acks += int'(o_ack);
    tick();
    acks += int'(o_ack);
    req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      acks += int'(o_ack);
    end
    check("busy_one_ack",    64'(acks), 64'(1));
    check("busy_one_strobe", 64'(rd_strobes - s_rd), 64'(1));
    check("busy_addr",       64'(last_addr), 64'(26'h10));

    // Reset during WAIT abandons the access.
    req  = 1'b1;
    addr = 26'h10;
    tick();
    req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_busy",   64'(o_busy),  64'(0));
    check("rst_ack",    64'(o_ack),   64'(0));
    check("rst_rdata",  64'(o_rdata), 64'(0));
    check("rst_strobe", 64'({o_mrd, o_mwr}), 64'(0));
    do_req(1'b0, 26'h10, 32'h0, lat);
    check("rst_fresh_latency", 64'(lat),     64'(3));
    check("rst_fresh_rdata",   64'(o_rdata), 64'(32'hDEADBEEF));
    tick();

    // Switch to the WAIT_CYCLES=3 instance.
    cmp_en = 1'b0;
    sel    = 1'b1;
    rst    = 1'b1;
    tick();
    tick();
    rst    = 1'b0;
    cmp_en = 1'b1;
    do_req(1'b0, 26'h10, 32'h0, lat);
    check("w3_rd_latency", 64'(lat),     64'(5));
    check("w3_rd_data",    64'(o_rdata), 64'(32'hDEADBEEF));
    do_req(1'b1, 26'h40, 32'hA5A5F00D, lat);
    check("w3_wr_latency", 64'(lat),     64'(5));
    do_req(1'b0, 26'h40, 32'h0, lat);
    check("w3_rd2_latency", 64'(lat),     64'(5));
    check("w3_rd2_data",    64'(o_rdata), 64'(32'hA5A5F00D));
    do_req(1'b0, 26'h3FFFFFF, 32'h0, lat);
    check("w3_err_latency", 64'(lat),   64'(1));
    check("w3_err_flag",    64'(o_err), 64'(1));
`ifdef MEM_ACCESS_CTRL_PERF_CNT_EN
    check("w3_rd_cnt",  64'(o_rdc), 64'(2));
    check("w3_wr_cnt",  64'(o_wrc), 64'(1));
    check("w3_err_cnt", 64'(o_erc), 64'(1));
`endif
    tick();

    random_phase(1500);

    cmp_en = 1'b0;
    sel    = 1'b0;
    rst    = 1'b1;
    tick();
    tick();
    rst    = 1'b0;
    cmp_en = 1'b1;
    random_phase(1500);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
